// File: rtl/life_pkg.sv
// Shared Life definitions: grid geometry, cell age codes and the display FSM
// state encoding. The rules engine and the LED serialiser both import this.
package life_pkg;

  localparam int unsigned N_ROWS  = 8;
  localparam int unsigned N_COLS  = 8;
  localparam int unsigned N_CELLS = N_ROWS * N_COLS;
  localparam int unsigned GRID_W  = 2 * N_CELLS;
  localparam int unsigned COLOR_W = 24;

  // Cell age codes: alive, then progressively older dead cells
  localparam logic [1:0] CELL_ALIVE = 2'b11;
  localparam logic [1:0] CELL_DEAD1 = 2'b01;
  localparam logic [1:0] CELL_DEAD2 = 2'b10;
  localparam logic [1:0] CELL_DEAD3 = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } disp_state_e;

endpackage

// File: rtl/grid_display_if.sv
// Frame request / status bundle between the sequencer and grid_display.
//   start : request to transmit grid (master -> slave)
//   grid  : 64 cells x 2-bit age code, cell i at grid[2*i +: 2]
//   busy  : frame in progress
//   done  : one-cycle pulse at end of frame (after latch time)
//   dout  : serial LED data line
interface grid_display_if;
  import life_pkg::*;

  logic              start;
  logic [GRID_W-1:0] grid;
  logic              busy;
  logic              done;
  logic              dout;

  modport master (output start, output grid, input busy, input done, input dout);
  modport slave  (input start, input grid, output busy, output done, output dout);
endinterface

// File: rtl/grid_display_bit_timer.sv
// ws_bit_timer: generates one WS2812 bit waveform of T_BIT cycles.
//   clk, reset : clock, synchronous active-high reset
//   go         : start a bit next cycle (may coincide with bit_done)
//   bit_val    : value of the bit started by go
//   dout       : registered line output, high T1H or T0H cycles
//   bit_done   : registered, high during the last cycle of the bit
module ws_bit_timer #(
  parameter int unsigned T0H   = 4,
  parameter int unsigned T1H   = 8,
  parameter int unsigned T_BIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int unsigned CNT_W = $clog2(T_BIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_len;
  logic             active;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = (CNT_W+1)'(cnt) + (CNT_W+1)'(1);

  // cnt is the index of the current cycle within the bit
  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      cnt      <= '0;
      high_len <= '0;
      dout     <= 1'b0;
      bit_done <= 1'b0;
    end else if (go) begin
      active   <= 1'b1;
      cnt      <= '0;
      high_len <= bit_val ? CNT_W'(T1H) : CNT_W'(T0H);
      dout     <= 1'b1;
      bit_done <= 1'b0;
    end else if (active) begin
      if (cnt == CNT_W'(T_BIT - 1)) begin
        active   <= 1'b0;
        dout     <= 1'b0;
        bit_done <= 1'b0;
      end else begin
        cnt      <= CNT_W'(cnt_inc);
        dout     <= cnt_inc < (CNT_W+1)'(high_len);
        bit_done <= (cnt == CNT_W'(T_BIT - 2));
      end
    end else begin
      dout     <= 1'b0;
      bit_done <= 1'b0;
    end
  end

endmodule

// File: rtl/grid_display.sv
// grid_display: snapshots an 8x8 Life grid on start and serialises it to a
// chain of 64 WS2812 LEDs (GRB, MSB first, cell 0 first), then holds the line
// low for the latch time.
//   clk, reset : clock, synchronous active-high reset
//   bus        : grid_display_if slave (start, grid in; busy, done, dout out)
module grid_display
  import life_pkg::*;
#(
  parameter int unsigned         T0H          = 4,
  parameter int unsigned         T1H          = 8,
  parameter int unsigned         T_BIT        = 15,
  parameter int unsigned         RESET_CYCLES = 600,
  parameter logic [COLOR_W-1:0]  COLOR_ALIVE  = 24'h30_00_00,
  parameter logic [COLOR_W-1:0]  COLOR_DEAD1  = 24'h08_08_00,
  parameter logic [COLOR_W-1:0]  COLOR_DEAD2  = 24'h00_00_04,
  parameter logic [COLOR_W-1:0]  COLOR_OFF    = 24'h00_00_00
) (
  input logic           clk,
  input logic           reset,
  grid_display_if.slave bus
);

  localparam int unsigned        PIX_W    = $clog2(N_CELLS);
  localparam int unsigned        LAT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [PIX_W-1:0]   PIX_LAST = PIX_W'(N_CELLS - 1);
  localparam logic [4:0]         BIT_LAST = 5'(COLOR_W - 1);

  function automatic logic [COLOR_W-1:0] color_of(input logic [1:0] code);
    case (code)
      CELL_ALIVE: return COLOR_ALIVE;
      CELL_DEAD1: return COLOR_DEAD1;
      CELL_DEAD2: return COLOR_DEAD2;
      default:    return COLOR_OFF;
    endcase
  endfunction

  disp_state_e        state;
  logic [GRID_W-1:0]  frame_q;
  logic [PIX_W-1:0]   pixel;
  logic [4:0]         bit_idx;
  logic [COLOR_W-1:0] shift_q;
  logic [LAT_W-1:0]   lat_cnt;

  logic [COLOR_W-1:0] shift_nxt;
  logic [COLOR_W-1:0] next_color;
  logic [PIX_W-1:0]   pixel_inc;
  logic               last_bit;
  logic               go;
  logic               bit_done;
  logic               line;

  assign pixel_inc  = PIX_W'(pixel + 1'b1);
  assign next_color = color_of(frame_q[{pixel_inc, 1'b0} +: 2]);
  assign last_bit   = (bit_idx == '0) && (pixel == PIX_LAST);

  // Next shift-register contents and bit launch, so the timer starts the
  // following bit in the same cycle the previous one ends.
  always_comb begin
    shift_nxt = shift_q;
    go        = 1'b0;
    case (state)
      ST_IDLE: begin
        go        = bus.start;
        shift_nxt = color_of(bus.grid[1:0]);
      end
      ST_HIGH, ST_LOW: begin
        if (bit_done) begin
          go        = !last_bit;
          shift_nxt = (bit_idx != '0) ? (shift_q << 1) : next_color;
        end
      end
      default: ;
    endcase
  end

  ws_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .T_BIT(T_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .bit_val (shift_nxt[COLOR_W-1]),
    .dout    (line),
    .bit_done(bit_done)
  );

  assign bus.dout = line;

  // Frame / pixel / bit sequencing and latch timing
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      frame_q  <= '0;
      pixel    <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      lat_cnt  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            frame_q  <= bus.grid;
            pixel    <= '0;
            bit_idx  <= BIT_LAST;
            shift_q  <= shift_nxt;
            state    <= ST_HIGH;
            bus.busy <= 1'b1;
          end
        end
        ST_HIGH, ST_LOW: begin
          // HIGH/LOW tracks the line phase one cycle behind the timer
          if (state == ST_HIGH && !line) state <= ST_LOW;
          if (bit_done) begin
            if (bit_idx != '0) begin
              shift_q <= shift_nxt;
              bit_idx <= bit_idx - 5'd1;
              state   <= ST_HIGH;
            end else if (pixel != PIX_LAST) begin
              shift_q <= shift_nxt;
              pixel   <= pixel_inc;
              bit_idx <= BIT_LAST;
              state   <= ST_HIGH;
            end else begin
              lat_cnt <= '0;
              state   <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (lat_cnt == LAT_W'(RESET_CYCLES - 1)) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            lat_cnt <= LAT_W'(lat_cnt + 1'b1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/grid_display.md
# grid_display

Serialises one 8x8 Life grid (64 cells × 2-bit age code) to a chain of 64 WS2812-style addressable LEDs over a single-wire NRZ line. It sits downstream of the rules engine and consumes its 128-bit `grid` output. Each frame is snapshotted on `start`, so the rules engine may step freely while the frame is on the wire. `done` tells the top-level sequencer when it may issue the next `step`/`start`.

## Interface
Parameters:
- `T0H`, 4: high cycles for a 0 bit (≈0.33 µs at 12 MHz).
- `T1H`, 8: high cycles for a 1 bit (≈0.67 µs).
- `T_BIT`, 15: total cycles per bit (≈1.25 µs); T0H < T1H < T_BIT.
- `RESET_CYCLES`, 600: low latch time after the last bit (50 µs).
- `COLOR_ALIVE`, 24'h30_00_00: GRB colour for code 2'b11.
- `COLOR_DEAD1`, 24'h08_08_00: GRB colour for code 2'b01.
- `COLOR_DEAD2`, 24'h00_00_04: GRB colour for code 2'b10.
- `COLOR_OFF`, 24'h00_00_00: GRB colour for code 2'b00.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request to transmit the current `grid`.
- `grid`, in, 128: cell `i` (`i = row*8+col`) is `grid[2*i +: 2]`.
- `busy`, out, 1: a frame is in progress.
- `done`, out, 1: one-cycle pulse when a frame, including the latch time, completes.
- `dout`, out, 1: serial LED data line.

## Operation
- Reset values: `busy`=0, `done`=0, `dout`=0; FSM in IDLE; counters cleared.
- FSM states: IDLE, HIGH, LOW, LATCH.
- IDLE: `dout`=0. `start`=1 captures `grid` into `frame_q`, sets pixel=0 and bit=23, loads `shift_q` with the colour of cell 0, and moves to HIGH.
  - `start` while not IDLE is ignored; no queueing.
- HIGH: `dout`=1 for T1H cycles if `shift_q[23]` is 1, else for T0H cycles, then moves to LOW.
- LOW: `dout`=0 for the remaining cycles, so every bit lasts exactly T_BIT cycles. At the end of the bit:
  - bit > 0: shift `shift_q` left, decrement bit, go to HIGH.
  - bit = 0, pixel < 63: increment pixel, load the next cell's colour, set bit=23, go to HIGH.
  - bit = 0, pixel = 63: go to LATCH.
- LATCH: `dout`=0 for RESET_CYCLES cycles, then go to IDLE.
- Colour map: 2'b11→COLOR_ALIVE, 2'b01→COLOR_DEAD1, 2'b10→COLOR_DEAD2, 2'b00→COLOR_OFF.
- Bit order: G[7:0], R[7:0], B[7:0], MSB first. Pixel order: cell 0 first, cell 63 last; the chain is wired linearly, not serpentine.
- `busy` = (state != IDLE).
- `done` is registered and high for exactly one cycle: the first IDLE cycle after LATCH.
- Changes on `grid` after capture have no effect on the frame in progress.
- `reset` mid-frame: in the next cycle `dout`=0, IDLE, `busy`=0, and no `done` pulse is produced.

## Timing
- `start` sampled high at edge n: `busy` and `dout` are both 1 from cycle n+1.
- Bit k of the frame (k = 0..1535) begins at cycle n+1+k·T_BIT.
- `busy` stays high for exactly 64·24·T_BIT + RESET_CYCLES cycles (23 640 with defaults).
- `done` is high in the first cycle with `busy`=0.
- `start` asserted in the `done` cycle is accepted, giving back-to-back frames with zero gap beyond the latch time.
- The colour lookup is combinational from `frame_q` indexed by the pixel counter and is loaded into `shift_q` at the bit boundary, so the next pixel's data costs no extra cycles.
- Counter widths:
  - pixel: 6 bits; terminates at 63 with no wrap.
  - bit: 5 bits.
  - cycle counter: ≥ clog2(max(T_BIT, RESET_CYCLES)) bits.

## Structure
- Shared package `life_pkg`:
  - `N_ROWS`=8, `N_COLS`=8, `N_CELLS`=64, `GRID_W`=128.
  - Cell-code constants `CELL_ALIVE`=2'b11, `CELL_DEAD1`=2'b01, `CELL_DEAD2`=2'b10, `CELL_DEAD3`=2'b00.
  - FSM state enum.
  - The rules engine imports the same cell codes.
- One sub-module, `ws_bit_timer`: given `go` and `bit_val`, it generates one T_BIT-long waveform and a `bit_done` pulse. `grid_display` owns the frame/pixel/bit sequencing and LATCH.

## Test plan
- **Reset state:** assert `reset` 3 cycles → `dout`=0, `busy`=0, `done`=0; `start` held low for 100 cycles → `dout` stays 0.
- **All-alive grid:** `grid`=all 1s, pulse `start` → first 24 bits decode to 0x300000 (high widths 4,4,8,8,4×20 in decoded bit order); 64 identical pixels; `busy` high 23 640 cycles; single `done` pulse.
- **Colour/order check:** cell 0=2'b01, cell 63=2'b10, rest 00 → pixel 0 decodes 0x080800, pixel 63 decodes 0x000004, others 0; every bit period measures 15 cycles.
- **Snapshot:** change `grid` 10 cycles after `start` → decoded frame matches the pre-start value.
- **Start handling:** `start` while busy → ignored, total frame length unchanged; `start` in the `done` cycle → next frame's first high begins in the following cycle.
- **Reset mid-frame:** `reset` at cycle 5000 → `dout`=0 and `busy`=0 on the next cycle, no `done` pulse; a subsequent `start` produces a full correct frame.
